// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one memory request port between the instruction
// fetch and data requesters. A four-state FSM (IDLE/ADDR/RESP/DONE) grants one
// requester, presents its latched request until accepted, waits for the
// response and pulses that requester's DONE with the registered read data.
// A transaction stuck in ADDR+RESP for TIMEOUT_CYCLES cycles is aborted with
// ARB_ERR (TIMEOUT_CYCLES = 0 disables the timeout).
// Optional macro CORE_ARB_RR_EN: simultaneous requests alternate between the
// requesters instead of giving the data port fixed priority.
module core_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  input  logic        i_dm_req,
  input  logic        i_dm_we,
  input  logic [31:0] i_dm_addr,
  input  logic [31:0] i_dm_wdata,
  input  logic [3:0]  i_dm_strb,
  output logic        o_bus_valid,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_strb,
  input  logic        i_bus_ready,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata,
  output logic        o_if_done,
  output logic        o_dm_done,
  output logic [31:0] o_arb_rdata,
  output logic        o_arb_err,
  output logic        o_arb_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP, S_DONE} state_t;

  // Counter is wide enough to reach TIMEOUT_CYCLES without wrapping.
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 2);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] TMO_LAST = TMO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_grant_dm;
  logic          r_bus_we;
  logic [31:0]   r_bus_addr;
  logic [31:0]   r_bus_wdata;
  logic [3:0]    r_bus_strb;
  logic [31:0]   r_arb_rdata;
  logic          r_arb_err;
  logic [CW-1:0] r_tmo_cnt;

  logic w_any_req;
  logic w_grant_dm;
  logic w_tmo_hit;
  logic w_take_resp;
  logic w_abort;
  logic w_grant;

  assign w_any_req = i_if_req | i_dm_req;
  // The cycle whose closing edge brings the counter to TIMEOUT_CYCLES.
  assign w_tmo_hit = TMO_EN && (r_tmo_cnt == TMO_LAST);

`ifdef CORE_ARB_RR_EN
  logic r_last_if;  // 1: IF won the last grant, 0: DM did (reset value)

  assign w_grant_dm = i_dm_req && (!i_if_req || r_last_if);

  // Remember which requester won so the other wins the next tie.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_if <= 1'b0;
    end else if (w_grant) begin
      r_last_if <= !w_grant_dm;
    end
  end
`else
  assign w_grant_dm = i_dm_req;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode plus the state-derived strobes; a response wins over a
  // timeout landing on the same cycle, a timeout wins over a late READY.
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_take_resp  = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_grant      = 1'b1;
          w_state_next = S_ADDR;
        end
      end
      S_ADDR: begin
        if (w_tmo_hit) begin
          w_abort      = 1'b1;
          w_state_next = S_DONE;
        end else if (i_bus_ready) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (i_bus_rvalid) begin
          w_take_resp  = 1'b1;
          w_state_next = S_DONE;
        end else if (w_tmo_hit) begin
          w_abort      = 1'b1;
          w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Request latch, response capture and timeout counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grant_dm  <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_strb  <= '0;
      r_arb_rdata <= '0;
      r_arb_err   <= 1'b0;
      r_tmo_cnt   <= '0;
    end else begin
      if (w_grant) begin
        r_grant_dm <= w_grant_dm;
        r_tmo_cnt  <= '0;
        if (w_grant_dm) begin
          r_bus_we    <= i_dm_we;
          r_bus_addr  <= i_dm_addr;
          r_bus_wdata <= i_dm_wdata;
          r_bus_strb  <= i_dm_strb;
        end else begin
          r_bus_we    <= 1'b0;
          r_bus_addr  <= i_if_addr;
          r_bus_wdata <= '0;
          r_bus_strb  <= 4'hF;
        end
      end else if (r_state == S_ADDR || r_state == S_RESP) begin
        r_tmo_cnt <= r_tmo_cnt + CW'(1);
      end
      if (w_take_resp) begin
        r_arb_rdata <= i_bus_rdata;
        r_arb_err   <= 1'b0;
      end else if (w_abort) begin
        r_arb_rdata <= '0;
        r_arb_err   <= 1'b1;
      end
    end
  end

  assign o_bus_valid = (r_state == S_ADDR);
  assign o_bus_we    = r_bus_we;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_wdata = r_bus_wdata;
  assign o_bus_strb  = r_bus_strb;
  assign o_if_done   = (r_state == S_DONE) && !r_grant_dm;
  assign o_dm_done   = (r_state == S_DONE) && r_grant_dm;
  assign o_arb_rdata = r_arb_rdata;
  // Error is only meaningful alongside the DONE pulse.
  assign o_arb_err   = (r_state == S_DONE) && r_arb_err;
  assign o_arb_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter. A second instance with a short timeout
// shares the stimulus and is only examined in the timeout scenario.
module tb_core_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [3:0]  dm_strb;
  logic        bus_ready, bus_rvalid;
  logic [31:0] bus_rdata;

  logic        bus_valid, bus_we, if_done, dm_done, arb_err, arb_busy;
  logic [31:0] bus_addr, bus_wdata, arb_rdata;
  logic [3:0]  bus_strb;

  logic        t_bus_valid, t_bus_we, t_if_done, t_dm_done, t_arb_err, t_arb_busy;
  logic [31:0] t_bus_addr, t_bus_wdata, t_arb_rdata;
  logic [3:0]  t_bus_strb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  core_mem_arbiter u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr),
    .i_dm_wdata(dm_wdata), .i_dm_strb(dm_strb),
    .o_bus_valid(bus_valid), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
    .o_bus_wdata(bus_wdata), .o_bus_strb(bus_strb),
    .i_bus_ready(bus_ready), .i_bus_rvalid(bus_rvalid), .i_bus_rdata(bus_rdata),
    .o_if_done(if_done), .o_dm_done(dm_done), .o_arb_rdata(arb_rdata),
    .o_arb_err(arb_err), .o_arb_busy(arb_busy)
  );

  core_mem_arbiter #(.TIMEOUT_CYCLES(4)) u_dut_tmo (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr),
    .i_dm_wdata(dm_wdata), .i_dm_strb(dm_strb),
    .o_bus_valid(t_bus_valid), .o_bus_we(t_bus_we), .o_bus_addr(t_bus_addr),
    .o_bus_wdata(t_bus_wdata), .o_bus_strb(t_bus_strb),
    .i_bus_ready(bus_ready), .i_bus_rvalid(bus_rvalid), .i_bus_rdata(bus_rdata),
    .o_if_done(t_if_done), .o_dm_done(t_dm_done), .o_arb_rdata(t_arb_rdata),
    .o_arb_err(t_arb_err), .o_arb_busy(t_arb_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, bus_valid, 0);
    check({tag, "_we"},    bus_we, 0);
    check({tag, "_addr"},  bus_addr, 0);
    check({tag, "_wdata"}, bus_wdata, 0);
    check({tag, "_strb"},  bus_strb, 0);
    check({tag, "_ifd"},   if_done, 0);
    check({tag, "_dmd"},   dm_done, 0);
    check({tag, "_rdata"}, arb_rdata, 0);
    check({tag, "_err"},   arb_err, 0);
    check({tag, "_busy"},  arb_busy, 0);
  endtask

  // Called with the main instance in ADDR: READY and RVALID on first offer.
  // Returns with the instance in DONE.
  task automatic serve_fast(input string tag, input logic [31:0] exp_addr,
                            input logic exp_dm, input logic [31:0] rd);
    check({tag, "_valid"}, bus_valid, 1);
    check({tag, "_addr"},  bus_addr, exp_addr);
    check({tag, "_busyA"}, arb_busy, 1);
    bus_ready = 1'b1;
    tick();
    check({tag, "_validR"}, bus_valid, 0);
    check({tag, "_busyR"},  arb_busy, 1);
    bus_ready  = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = rd;
    tick();
    bus_rvalid = 1'b0;
    check({tag, "_ifd"},   if_done, !exp_dm);
    check({tag, "_dmd"},   dm_done, exp_dm);
    check({tag, "_rdata"}, arb_rdata, rd);
    check({tag, "_err"},   arb_err, 0);
    check({tag, "_busyD"}, arb_busy, 1);
    $display("txn %s addr=0x%08h dm=%0d rdata=0x%08h", tag, bus_addr, dm_done, arb_rdata);
  endtask

  initial begin
    logic exp_dm;
    logic [31:0] exp_addr;

    rst = 1'b1;
    if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; dm_strb = 0;
    bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
    tick();
    tick();
    check_zero("rst");
    rst = 1'b0;
    tick();
    check("idle_busy", arb_busy, 0);

    // IF-only read, minimum latency: grant edge, READY, RVALID, DONE at t+3.
    if_req = 1'b1; if_addr = 32'h0000_0040;
    tick();
    check("if_we", bus_we, 0);
    check("if_wdata", bus_wdata, 0);
    check("if_strb", bus_strb, 4'hF);
    serve_fast("if_rd", 32'h40, 1'b0, 32'h0051_3023);
    if_req = 1'b0;
    tick();
    check("if_after_ifd", if_done, 0);
    check("if_after_busy", arb_busy, 0);

    // DM store, READY low for 5 cycles; fields changed after grant must not leak.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h3000;
    dm_wdata = 32'hDEAD_BEEF; dm_strb = 4'b0011;
    tick();
    dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0; dm_strb = 4'hF;
    for (int k = 0; k < 5; k++) begin
      check("st_valid", bus_valid, 1);
      check("st_we", bus_we, 1);
      check("st_addr", bus_addr, 32'h3000);
      check("st_wdata", bus_wdata, 32'hDEAD_BEEF);
      check("st_strb", bus_strb, 4'b0011);
      bus_rvalid = (k == 2);  // early response in ADDR is ignored
      bus_rdata  = 32'h5555_AAAA;
      tick();
    end
    bus_rvalid = 1'b0;
    check("st_valid6", bus_valid, 1);
    check("st_dmd_early", dm_done, 0);
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    check("st_validR", bus_valid, 0);
    check("st_dmdR", dm_done, 0);
    bus_rvalid = 1'b1; bus_rdata = 32'h0000_0001;
    tick();
    bus_rvalid = 1'b0;
    check("st_dmd", dm_done, 1);
    check("st_ifd", if_done, 0);
    check("st_rdata", arb_rdata, 32'h1);
    check("st_err", arb_err, 0);
    $display("txn store addr=0x%08h dm=%0d", bus_addr, dm_done);
    dm_req = 1'b0;
    tick();
    check("st_after_dmd", dm_done, 0);
    check("st_after_busy", arb_busy, 0);

    // Simultaneous requests: order depends on arbitration mode.
    if_req = 1'b1; if_addr = 32'h100;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000; dm_strb = 4'hF;
    tick();
`ifdef CORE_ARB_RR_EN
    serve_fast("sim1", 32'h100, 1'b0, 32'h11);
    if_req = 1'b0;
`else
    serve_fast("sim1", 32'h2000, 1'b1, 32'h11);
    dm_req = 1'b0;
`endif
    tick();
    check("sim_gap_busy", arb_busy, 0);
    tick();
`ifdef CORE_ARB_RR_EN
    serve_fast("sim2", 32'h2000, 1'b1, 32'h22);
`else
    serve_fast("sim2", 32'h100, 1'b0, 32'h22);
`endif
    if_req = 1'b0; dm_req = 1'b0;
    tick();

    // Continuous requests from both sides for 8 transactions.
    if_req = 1'b1; dm_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
`ifdef CORE_ARB_RR_EN
      exp_dm = (i % 2 == 1);
`else
      exp_dm = 1'b1;
`endif
      exp_addr = exp_dm ? 32'h2000 : 32'h100;
      serve_fast("cont", exp_addr, exp_dm, 32'h1000 + i);
      tick();
      check("cont_idle_busy", arb_busy, 0);
      if (i == 7) begin
        if_req = 1'b0; dm_req = 1'b0;
      end
    end
    tick();
    check("cont_end_busy", arb_busy, 0);

    // Reset while waiting for the response; late RVALID must be ignored.
    if_req = 1'b1; if_addr = 32'h80;
    tick();
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    check("rr_in_resp", arb_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; if_req = 1'b0;
    check_zero("midrst");
    bus_rvalid = 1'b1; bus_rdata = 32'h1234;
    tick();
    bus_rvalid = 1'b0;
    check("late_ifd", if_done, 0);
    check("late_busy", arb_busy, 0);
    check("late_rdata", arb_rdata, 0);
    bus_ready = 1'b1;  // stray READY in IDLE
    tick();
    bus_ready = 1'b0;
    check("stray_ready_busy", arb_busy, 0);
    check("stray_ready_valid", bus_valid, 0);
    $display("txn reset_mid_resp done");

    // Timeout on the TIMEOUT_CYCLES=4 instance; first load a nonzero rdata.
    if_req = 1'b1; if_addr = 32'h40;
    tick();
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hA5A5_5A5A;
    tick();
    bus_rvalid = 1'b0;
    check("tmo_pre_ifd", t_if_done, 1);
    check("tmo_pre_rdata", t_arb_rdata, 32'hA5A5_5A5A);
    if_req = 1'b0;
    tick();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h4000;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("tmo_valid", t_bus_valid, 1);
      check("tmo_dmd_early", t_dm_done, 0);
      tick();
    end
    check("tmo_dmd", t_dm_done, 1);
    check("tmo_err", t_arb_err, 1);
    check("tmo_rdata", t_arb_rdata, 0);
    check("tmo_valid_off", t_bus_valid, 0);
    $display("txn timeout addr=0x%08h err=%0d", t_bus_addr, t_arb_err);
    dm_req = 1'b0;
    tick();
    check("tmo_after_dmd", t_dm_done, 0);
    check("tmo_after_busy", t_arb_busy, 0);
    check("tmo_after_err", t_arb_err, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 The parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum number of cycles spent in ADDR+RESP before a transaction is aborted; 0 disables the timeout.
REQ-002 CLK  in  1  single clock; all logic SHALL be rising-edge triggered.
REQ-003 RST  in  1  reset, synchronous and active-high.
REQ-004 IF_REQ  in  1  instruction-fetch request (read only), held high until IF_DONE.
REQ-005 IF_ADDR  in  32  fetch address.
REQ-006 DM_REQ  in  1  data request, held high until DM_DONE.
REQ-007 DM_WE  in  1  1 = store, 0 = load.
REQ-008 DM_ADDR / DM_WDATA / DM_STRB  in  32/32/4  data address, store data, byte strobes.
REQ-009 BUS_VALID  out  1  request valid toward the shared memory port.
REQ-010 BUS_WE / BUS_ADDR / BUS_WDATA / BUS_STRB  out  1/32/32/4  latched request fields.
REQ-011 BUS_READY  in  1  memory accepts the request.
REQ-012 BUS_RVALID / BUS_RDATA  in  1/32  response valid and read data (stores also return RVALID).
REQ-013 IF_DONE / DM_DONE  out  1  one-cycle completion pulse to the owning requester.
REQ-014 ARB_RDATA  out  32  registered read data, valid while a DONE pulse is high.
REQ-015 ARB_ERR  out  1  high with DONE when the transaction timed out.
REQ-016 ARB_BUSY  out  1  high whenever the state is not IDLE; feeds the pipeline stall logic.

Function
REQ-017 The FSM SHALL have four states: IDLE, ADDR, RESP, DONE.
REQ-018 IDLE: if any REQ is high, the FSM SHALL grant one requester, latch its fields into the BUS_* registers and enter ADDR on the next edge. IF requests SHALL drive BUS_WE=0, BUS_WDATA=0, BUS_STRB=4'hF.
REQ-019 Arbitration with no configuration macro: DM SHALL have fixed priority over IF on simultaneous requests.
REQ-020 ADDR: BUS_VALID=1 and the BUS_* fields SHALL be held stable. On BUS_READY=1 the FSM SHALL enter RESP.
REQ-021 RESP: BUS_VALID=0. On BUS_RVALID=1 the FSM SHALL capture BUS_RDATA into ARB_RDATA, set ARB_ERR=0 and enter DONE.
REQ-022 DONE: the granted requester's DONE SHALL be high for exactly this cycle; the FSM SHALL return to IDLE unconditionally.
REQ-023 Minimum latency: REQ sampled in IDLE at cycle t, with READY and RVALID each high on the first cycle offered, SHALL give DONE at cycle t+3.
REQ-024 Back-to-back: a new grant SHALL be possible in the IDLE cycle that immediately follows DONE. Requesters deassert REQ on the edge that ends DONE.
REQ-025 Request fields and REQ changes after the grant SHALL be ignored until DONE. A REQ dropped mid-transaction SHALL NOT abort the bus transaction.
REQ-026 Timeout (TIMEOUT_CYCLES > 0):
- A counter SHALL clear on entering ADDR and increment every cycle in ADDR or RESP.
- When the counter equals TIMEOUT_CYCLES, the FSM SHALL enter DONE with ARB_ERR=1 and ARB_RDATA=0.
- BUS_VALID SHALL be low from that edge onward.
REQ-027 A BUS_RVALID arriving in IDLE or ADDR SHALL be ignored.
REQ-028 A BUS_READY arriving outside ADDR SHALL be ignored.

Reset
REQ-029 RST=1 SHALL force IDLE from any state, including mid-transaction, with no DONE pulse.
REQ-030 RST=1 SHALL clear BUS_VALID, BUS_WE, BUS_ADDR, BUS_WDATA, BUS_STRB, IF_DONE, DM_DONE, ARB_RDATA, ARB_ERR, ARB_BUSY, the timeout counter and the round-robin pointer to 0.

Configuration
REQ-031 With CORE_ARB_RR_EN defined, simultaneous requests SHALL be granted to the requester that was not granted last. The last-grant pointer SHALL update on every grant and reset to "DM last", so that IF wins the first tie.
REQ-032 Without CORE_ARB_RR_EN, the fixed DM priority of REQ-019 SHALL apply and no pointer register SHALL exist.

Verification
REQ-033 IF-only read: IF_REQ=1, IF_ADDR=0x0000_0040, READY at cycle 1, RVALID at cycle 2 with RDATA=0x0051_3023 -> IF_DONE=1 at cycle 3, ARB_RDATA=0x0051_3023, ARB_ERR=0.
REQ-034 Simultaneous requests (IF_ADDR=0x100, DM load DM_ADDR=0x2000) without CORE_ARB_RR_EN -> BUS_ADDR=0x2000 first, then 0x100. With CORE_ARB_RR_EN -> 0x100 first, then 0x2000.
REQ-035 DM store of DM_WDATA=0xDEAD_BEEF, DM_STRB=4'b0011 with READY held low for 5 cycles -> BUS_VALID and all fields stable for those 5 cycles; DM_DONE exactly 1 cycle after RVALID.
REQ-036 TIMEOUT_CYCLES=4, READY never asserted -> BUS_VALID high for 4 cycles, then DM_DONE=1, ARB_ERR=1, ARB_RDATA=0.
REQ-037 RST pulsed while in RESP -> next cycle IDLE, all outputs 0, no DONE pulse; a late BUS_RVALID is ignored.
REQ-038 Continuous IF_REQ and DM_REQ for 8 transactions with CORE_ARB_RR_EN -> grants alternate IF, DM, IF, DM; ARB_BUSY low only in the single IDLE cycles between them.
